// File: rtl/alu_op_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_pkg
// Description : Shared constants for the ALU operation sequencer.
//               Contents: ALU control-line codes, request op codes, FSM state
//               encoding, the data width and the multiply iteration count.
//               Optional macro: ALUSEQ_MUL_EN makes op 8 (MUL) a legal op.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    localparam int DATA_W    = 32;
    localparam int MUL_ITERS = 32;  // one shift-add step per multiplier bit

    // ALU control line (gin) codes
    localparam logic [2:0] GIN_AND   = 3'b000;
    localparam logic [2:0] GIN_OR    = 3'b001;
    localparam logic [2:0] GIN_ADD   = 3'b010;
    localparam logic [2:0] GIN_PASSA = 3'b011;
    localparam logic [2:0] GIN_SRLV  = 3'b100;
    localparam logic [2:0] GIN_SUB   = 3'b110;
    localparam logic [2:0] GIN_SLT   = 3'b111;

    // Request op codes
    localparam logic [3:0] OP_ADD     = 4'd0;
    localparam logic [3:0] OP_SUB     = 4'd1;
    localparam logic [3:0] OP_AND     = 4'd2;
    localparam logic [3:0] OP_OR      = 4'd3;
    localparam logic [3:0] OP_SLT     = 4'd4;
    localparam logic [3:0] OP_PASSA   = 4'd5;
    localparam logic [3:0] OP_SRLV    = 4'd6;
    localparam logic [3:0] OP_MUL     = 4'd8;
    localparam logic [3:0] OP_ABSDIFF = 4'd9;
    localparam logic [3:0] OP_MAX     = 4'd10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EXEC  = 3'd1,
        ST_EXEC2 = 3'd2,
        ST_MUL   = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    // Control line for the single-pass ops; anything else gets ADD.
    function automatic logic [2:0] op_gin(input logic [3:0] op);
        logic [2:0] g;
        g = GIN_ADD;
        case (op)
            OP_ADD:   g = GIN_ADD;
            OP_SUB:   g = GIN_SUB;
            OP_AND:   g = GIN_AND;
            OP_OR:    g = GIN_OR;
            OP_SLT:   g = GIN_SLT;
            OP_PASSA: g = GIN_PASSA;
            OP_SRLV:  g = GIN_SRLV;
            default:  g = GIN_ADD;
        endcase
        return g;
    endfunction

    function automatic logic op_legal(input logic [3:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_PASSA, OP_SRLV,
            OP_ABSDIFF, OP_MAX: ok = 1'b1;
`ifdef ALUSEQ_MUL_EN
            OP_MUL: ok = 1'b1;
`endif
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_op_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_sequencer_if
// Description : Bundle of the request channel, response channel and ALU bus
//               of the ALU operation sequencer.
//               slave  : the sequencer itself
//               master : its environment (requester, consumer and the ALU)
//               Request : req_valid, req_ready, req_op[3:0], req_a, req_b
//               ALU     : alu_a, alu_b, alu_gin[2:0] out; alu_sum, alu_zout,
//                         alu_nout, alu_ovf back
//               Response: rsp_valid, rsp_ready, rsp_result, rsp_zero,
//                         rsp_neg, rsp_ovf; plus busy
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_op_sequencer_if;
    import alu_seq_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_op;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [2:0]        alu_gin;
    logic [DATA_W-1:0] alu_sum;
    logic              alu_zout;
    logic              alu_nout;
    logic              alu_ovf;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_zero;
    logic              rsp_neg;
    logic              rsp_ovf;
    logic              busy;

    modport slave (
        input  req_valid, req_op, req_a, req_b,
        output req_ready,
        output alu_a, alu_b, alu_gin,
        input  alu_sum, alu_zout, alu_nout, alu_ovf,
        output rsp_valid, rsp_result, rsp_zero, rsp_neg, rsp_ovf,
        input  rsp_ready,
        output busy
    );

    modport master (
        output req_valid, req_op, req_a, req_b,
        input  req_ready,
        input  alu_a, alu_b, alu_gin,
        output alu_sum, alu_zout, alu_nout, alu_ovf,
        input  rsp_valid, rsp_result, rsp_zero, rsp_neg, rsp_ovf,
        output rsp_ready,
        input  busy
    );

endinterface
`default_nettype wire

// File: rtl/alu_seq_mul_step.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_mul_step
// Description : Shift-add multiply datapath registers for the sequencer.
//               The external ALU does the additions: each cycle it is driven
//               with acc + mcand, and on a step the sum is kept when the low
//               multiplier bit is set.
//               clk, reset     : clock, asynchronous active-high reset
//               start          : load acc=0, mcand=a, mplr=b, cnt=0
//               step           : perform one iteration
//               a, b           : operands
//               alu_sum        : ALU result for acc + mcand
//               acc_nxt        : accumulator value after this step
//               mcand_nxt      : multiplicand value after this step
//               last           : this step is the final iteration
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_mul_step
    import alu_seq_pkg::*;
#(
    parameter int ITERS = MUL_ITERS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              step,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] alu_sum,
    output logic [DATA_W-1:0] acc_nxt,
    output logic [DATA_W-1:0] mcand_nxt,
    output logic              last
);

    localparam int CNT_W = $clog2(ITERS);

    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplr;
    logic [CNT_W-1:0]  cnt;

    assign acc_nxt   = mplr[0] ? alu_sum : acc;
    assign mcand_nxt = {mcand[DATA_W-2:0], 1'b0};
    assign last      = (cnt == CNT_W'(ITERS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc   <= '0;
            mcand <= '0;
            mplr  <= '0;
            cnt   <= '0;
        end else if (start) begin
            acc   <= '0;
            mcand <= a;
            mplr  <= b;
            cnt   <= '0;
        end else if (step) begin
            acc   <= acc_nxt;
            mcand <= mcand_nxt;
            mplr  <= {1'b0, mplr[DATA_W-1:1]};
            cnt   <= cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_sequencer
// Description : Issue-side sequencer for an external combinational 32-bit
//               ALU. Accepts one op over req valid/ready, drives registered
//               ALU operands and control, samples the ALU flags and returns
//               a registered response over rsp valid/ready. ABSDIFF and MAX
//               take two ALU passes; MUL is a 32-step shift-add loop.
//               clk   : clock, rising edge
//               reset : asynchronous active-high reset
//               bus   : request / ALU / response bundle (slave side)
//               Optional macro: ALUSEQ_MUL_EN enables op 8 (MUL); without it
//               op 8 is treated as illegal and the multiply logic is absent.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_sequencer
    import alu_seq_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    alu_op_sequencer_if.slave  bus
);

    state_t            state, state_nxt;
    logic [3:0]        op_q, op_nxt;
    logic [DATA_W-1:0] a_q, a_nxt;
    logic [DATA_W-1:0] b_q, b_nxt;
    logic [DATA_W-1:0] alu_a_q, alu_a_nxt;
    logic [DATA_W-1:0] alu_b_q, alu_b_nxt;
    logic [2:0]        gin_q, gin_nxt;
    logic [DATA_W-1:0] res_q, res_nxt;
    logic              zero_q, zero_nxt;
    logic              neg_q, neg_nxt;
    logic              ovf_q, ovf_nxt;
    logic              less;

    // The first pass of ABSDIFF/MAX is SLT, so bit 0 of its result is "a < b".
    assign less = bus.alu_sum[0];

`ifdef ALUSEQ_MUL_EN
    logic              mul_start;
    logic              mul_step;
    logic [DATA_W-1:0] acc_nxt;
    logic [DATA_W-1:0] mcand_nxt;
    logic              mul_last;

    alu_seq_mul_step #(
        .ITERS (MUL_ITERS)
    ) u_mul_step (
        .clk       (clk),
        .reset     (reset),
        .start     (mul_start),
        .step      (mul_step),
        .a         (bus.req_a),
        .b         (bus.req_b),
        .alu_sum   (bus.alu_sum),
        .acc_nxt   (acc_nxt),
        .mcand_nxt (mcand_nxt),
        .last      (mul_last)
    );
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_a_q <= '0;
            alu_b_q <= '0;
            gin_q   <= GIN_ADD;
            res_q   <= '0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            op_q    <= op_nxt;
            a_q     <= a_nxt;
            b_q     <= b_nxt;
            alu_a_q <= alu_a_nxt;
            alu_b_q <= alu_b_nxt;
            gin_q   <= gin_nxt;
            res_q   <= res_nxt;
            zero_q  <= zero_nxt;
            neg_q   <= neg_nxt;
            ovf_q   <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        op_nxt    = op_q;
        a_nxt     = a_q;
        b_nxt     = b_q;
        alu_a_nxt = alu_a_q;
        alu_b_nxt = alu_b_q;
        gin_nxt   = gin_q;
        res_nxt   = res_q;
        zero_nxt  = zero_q;
        neg_nxt   = neg_q;
        ovf_nxt   = ovf_q;
`ifdef ALUSEQ_MUL_EN
        mul_start = 1'b0;
        mul_step  = 1'b0;
`endif

        case (state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    op_nxt    = bus.req_op;
                    a_nxt     = bus.req_a;
                    b_nxt     = bus.req_b;
                    state_nxt = ST_EXEC;
                    alu_a_nxt = bus.req_a;
                    alu_b_nxt = bus.req_b;
                    if (!op_legal(bus.req_op)) begin
                        // Illegal ops idle the ALU on 0 + 0.
                        alu_a_nxt = '0;
                        alu_b_nxt = '0;
                        gin_nxt   = GIN_ADD;
                    end else if (bus.req_op == OP_ABSDIFF ||
                                 bus.req_op == OP_MAX) begin
                        gin_nxt = GIN_SLT;
`ifdef ALUSEQ_MUL_EN
                    end else if (bus.req_op == OP_MUL) begin
                        // First step adds mcand to the cleared accumulator.
                        mul_start = 1'b1;
                        alu_a_nxt = '0;
                        alu_b_nxt = bus.req_a;
                        gin_nxt   = GIN_ADD;
                        state_nxt = ST_MUL;
`endif
                    end else begin
                        gin_nxt = op_gin(bus.req_op);
                    end
                end
            end

            ST_EXEC: begin
                if (op_q == OP_ABSDIFF) begin
                    // Subtract the smaller from the larger.
                    gin_nxt   = GIN_SUB;
                    alu_a_nxt = less ? b_q : a_q;
                    alu_b_nxt = less ? a_q : b_q;
                    state_nxt = ST_EXEC2;
                end else if (op_q == OP_MAX) begin
                    gin_nxt   = GIN_PASSA;
                    alu_a_nxt = less ? b_q : a_q;
                    alu_b_nxt = b_q;
                    state_nxt = ST_EXEC2;
                end else begin
                    state_nxt = ST_RESP;
                    if (op_legal(op_q)) begin
                        res_nxt  = bus.alu_sum;
                        zero_nxt = bus.alu_zout;
                        neg_nxt  = bus.alu_nout;
                        ovf_nxt  = (op_q == OP_ADD || op_q == OP_SUB) ?
                                   bus.alu_ovf : 1'b0;
                    end else begin
                        res_nxt  = '0;
                        zero_nxt = 1'b1;
                        neg_nxt  = 1'b0;
                        ovf_nxt  = 1'b0;
                    end
                end
            end

            ST_EXEC2: begin
                res_nxt   = bus.alu_sum;
                zero_nxt  = bus.alu_zout;
                neg_nxt   = bus.alu_nout;
                ovf_nxt   = (op_q == OP_ABSDIFF) ? bus.alu_ovf : 1'b0;
                state_nxt = ST_RESP;
            end

`ifdef ALUSEQ_MUL_EN
            ST_MUL: begin
                // Keep the ALU operands tracking the updated acc/mcand so
                // the next cycle's sum is ready at the next step.
                mul_step  = 1'b1;
                alu_a_nxt = acc_nxt;
                alu_b_nxt = mcand_nxt;
                if (mul_last) begin
                    res_nxt   = acc_nxt;
                    zero_nxt  = (acc_nxt == '0);
                    neg_nxt   = acc_nxt[DATA_W-1];
                    ovf_nxt   = 1'b0;
                    state_nxt = ST_RESP;
                end
            end
`endif

            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.req_ready  = (state == ST_IDLE);
    assign bus.busy       = (state != ST_IDLE);
    assign bus.rsp_valid  = (state == ST_RESP);
    assign bus.rsp_result = res_q;
    assign bus.rsp_zero   = zero_q;
    assign bus.rsp_neg    = neg_q;
    assign bus.rsp_ovf    = ovf_q;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_gin    = gin_q;

endmodule
`default_nettype wire
